// File: rtl/dp_accumulator_if.sv
// Stream handshake bundle for dp_accumulator: partial-sum input side and
// quantized-activation output side.
interface dp_accumulator_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    // master: the producer of partial sums and consumer of results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dp_accumulator.sv
// Accumulates cfg_len signed partial sums plus a bias, then requantizes the
// total to a signed OUT_W activation. Macro DP_ACCUMULATOR_RELU_EN clamps negatives to 0.
module dp_accumulator #(
    parameter int IN_W    = 32,
    parameter int LEN_W   = 8,
    parameter int SHIFT_W = 5,
    parameter int OUT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    input  logic signed [IN_W-1:0] cfg_bias,
    dp_accumulator_if.slave        bus,
    output logic                   busy
);
    // Wide enough for (2^LEN_W - 1) beats plus the bias without overflow.
    localparam int AW = IN_W + LEN_W + 1;

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

    state_e                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d, len_q, len_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    in_fire, out_fire;

    function automatic logic signed [AW-1:0] sext(input logic signed [IN_W-1:0] x);
        return {{(AW-IN_W){x[IN_W-1]}}, x};
    endfunction

    // Round half toward +inf, arithmetic shift, saturate; one spare bit absorbs the rounding add.
    function automatic logic signed [OUT_W-1:0] quantize(input logic signed [AW-1:0] x,
                                                         input logic [SHIFT_W-1:0] sh);
        logic signed [AW:0] xe, rnd, r, hi, lo;
        xe = {x[AW-1], x};
`ifdef DP_ACCUMULATOR_RELU_EN
        if (xe < 0) xe = '0;
`else
`endif
        if (sh != '0) begin
            rnd = (AW+1)'(1) << (sh - 1'b1);
            r   = (xe + rnd) >>> sh;
        end else begin
            r = xe;
        end
        hi = ((AW+1)'(1) << (OUT_W-1)) - (AW+1)'(1);
        lo = -hi - (AW+1)'(1);
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r[OUT_W-1:0];
    endfunction

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        shift_d     = shift_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: if (in_fire) begin
                // Bias is folded in on the first beat, so only len/shift need holding.
                len_d   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                shift_d = cfg_shift;
                acc_d   = sext(cfg_bias) + sext(bus.in_data);
                cnt_d   = LEN_W'(1);
                state_d = (len_d <= LEN_W'(1)) ? OUT : ACC;
            end
            ACC: if (in_fire) begin
                acc_d = acc_q + sext(bus.in_data);
                cnt_d = cnt_q + LEN_W'(1);
                if (cnt_d == len_q) state_d = OUT;
            end
            OUT: if (out_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != OUT && state_d == OUT) begin
            out_valid_d = 1'b1;
            out_data_d  = quantize(acc_d, shift_d);
        end
        if (out_fire) out_valid_d = 1'b0;
        in_ready_d = (state_d != OUT);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_dp_accumulator.sv
// Directed bench for dp_accumulator with hand-computed expectations.
module tb_dp_accumulator;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        cfg_len = '0;
    logic [4:0]        cfg_shift = '0;
    logic signed [31:0] cfg_bias = '0;
    logic              busy;
    int                n_cmp = 0;
    int                n_bad = 0;

    dp_accumulator_if #(.IN_W(32), .OUT_W(8)) bus ();

    dp_accumulator #(.IN_W(32), .LEN_W(8), .SHIFT_W(5), .OUT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .cfg_bias  (cfg_bias),
        .bus       (bus.slave),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic send(input int d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Wait for a result, check it, then complete the handshake.
    task automatic take(input string tag, input int exp);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk(tag, int'(bus.out_data), exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, int'(bus.out_valid), 0);
    endtask

    task automatic cfg(input int len, input int shift, input int bias);
        cfg_len   = 8'(len);
        cfg_shift = 5'(shift);
        cfg_bias  = bias;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick(2);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Single beat: one-cycle latency, busy clears after handshake.
        cfg(1, 0, 0);
        send(5);
        chk("single_lat", int'(bus.out_valid), 1);
        chk("single_busy", int'(busy), 1);
        chk("single_rdy", int'(bus.in_ready), 0);
        take("single", 5);
        chk("single_idle", int'(busy), 0);
        chk("single_rdy2", int'(bus.in_ready), 1);

        // Multi-beat with gaps and rounding; mid-group cfg changes are ignored.
        cfg(4, 2, 10);
        send(100);
        cfg(2, 0, 999);
        tick(2);
        chk("multi_busy", int'(busy), 1);
        send(200);
        send(-50);
        tick();
        chk("multi_nout", int'(bus.out_valid), 0);
        send(40);
        take("multi", 75);

        // Saturation both ways.
        cfg(2, 0, 0);
        send(1000);
        send(1000);
        take("sat_hi", 127);
        send(-1000);
        send(-1000);
`ifdef DP_ACCUMULATOR_RELU_EN
        take("sat_lo", 0);
`else
        take("sat_lo", -128);
`endif

        // Rounding of negatives, half toward +inf.
        cfg(1, 1, 0);
        send(-3);
`ifdef DP_ACCUMULATOR_RELU_EN
        take("rnd_m3", 0);
`else
        take("rnd_m3", -1);
`endif
        send(3);
        take("rnd_p3", 2);
        send(-40);
`ifdef DP_ACCUMULATOR_RELU_EN
        take("rnd_m40", 0);
`else
        take("rnd_m40", -20);
`endif

        // cfg_len of 0 behaves as 1.
        cfg(0, 0, 0);
        send(7);
        take("len0", 7);

        // Backpressure: result held, offered beats refused.
        cfg(1, 0, 0);
        send(9);
        bus.in_valid = 1'b1;
        bus.in_data  = 50;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_data", int'(bus.out_data), 9);
            chk("bp_rdy", int'(bus.in_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_drop", int'(bus.out_valid), 0);
        chk("bp_rdy_back", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_next_lat", int'(bus.out_valid), 1);
        take("bp_next", 50);

        // Reset mid-group aborts it.
        cfg(4, 0, 0);
        send(3);
        send(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_rdy", int'(bus.in_ready), 1);
        chk("rst_mid_busy", int'(busy), 0);
        tick(3);
        chk("rst_mid_nout", int'(bus.out_valid), 0);
        for (int i = 0; i < 4; i++) send(1);
        take("rst_mid_new", 4);

        // Reset while a result is pending drops it.
        cfg(1, 0, 0);
        send(20);
        chk("rst_out_pend", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_out_drop", int'(bus.out_valid), 0);
        chk("rst_out_zero", int'(bus.out_data), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dp_accumulator.md
Name: dp_accumulator

Overview:
- Stage directly downstream of the parallel dot-product datapath.
- Consumes a stream of signed 32-bit partial dot-product sums. Accumulates cfg_len consecutive sums into one output neuron and adds a per-neuron bias.
- Requantizes the total (rounding arithmetic right shift, then saturation) to a signed 8-bit activation for the next layer.
- Uses valid/ready handshakes on both sides.

Parameters:
- IN_W, 32, width of incoming partial sum (signed).
- LEN_W, 8, width of cfg_len; sets the maximum number of beats per output.
- SHIFT_W, 5, width of cfg_shift.
- OUT_W, 8, width of quantized output (signed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_len  in  LEN_W  partial sums per output; 0 is treated as 1.
- cfg_shift  in  SHIFT_W  requantize right-shift amount.
- cfg_bias  in  IN_W  signed bias added once per output.
- in_valid  in  1  partial sum valid.
- in_ready  out  1  stage can accept a partial sum.
- in_data  in  IN_W  signed partial sum.
- out_valid  out  1  quantized result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  signed saturated result.
- busy  out  1  a group is in progress (state != IDLE).

Behaviour:
- Reset and handshake
  - Synchronous, active-low reset: rst_n sampled low at a clk edge resets everything.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, accumulator=0, count=0.
  - An input beat is accepted when in_valid && in_ready at a rising edge. An output beat is accepted when out_valid && out_ready.
  - All outputs are registered.
- Accumulator
  - Internal width is IN_W+LEN_W+1 bits, signed.
  - No overflow is possible for any legal cfg_len; no wrap handling is needed.
- FSM states: IDLE, ACC, OUT.
  - IDLE: in_ready=1. On an accepted beat:
    - latch cfg_len, cfg_shift and cfg_bias for the whole group;
    - acc = sext(cfg_bias) + sext(in_data); count=1.
    - If the latched len <= 1, go to OUT. Otherwise go to ACC.
  - ACC: in_ready=1. On an accepted beat: acc += sext(in_data); count++. When count reaches len, go to OUT.
    - Cycles with no beat hold state; gaps are allowed.
  - OUT: entered on the edge after the last beat is accepted.
    - out_valid=1 and out_data=quantize(acc) are both registered on that same edge, so latency is 1 cycle from the last accepted beat.
    - in_ready=0 throughout OUT.
    - out_data stays stable while out_valid && !out_ready.
    - On the output handshake: out_valid=0 and go to IDLE. in_ready returns to 1 on the following edge, giving one bubble cycle between groups.
- quantize(x)
  - If shift > 0: r = (x + (1 << (shift-1))) >>> shift, i.e. round half toward +inf.
  - If shift = 0: r = x.
  - Saturate r to [-128, 127] for OUT_W=8; in general to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Configuration timing
  - Configuration changes mid-group have no effect until the next group starts.
- Reset mid-operation
  - rst_n low in any state aborts the group.
  - Any pending output is discarded; out_valid drops on the reset edge.

Optional Feature:
- Macro: DP_ACCUMULATOR_RELU_EN.
  - Defined: after bias addition and before shift/saturate, a negative acc is replaced by 0, so out_data is always in [0, 127].
  - Undefined: no clamping; the full signed range is produced.

Test Plan:
- Single beat: cfg_len=1, bias=0, shift=0; in_data=5 → out_valid high 1 cycle later, out_data=5; busy returns to 0 after handshake.
- Multi-beat with rounding: cfg_len=4, bias=10, shift=2; beats 100, 200, -50, 40 with gaps → acc=300, out_data=(300+2)>>>2=75.
- Saturation: cfg_len=2, shift=0; beats 1000, 1000 → 127. Beats -1000, -1000 → -128 (or 0 with DP_ACCUMULATOR_RELU_EN).
- Negative rounding: cfg_len=1, shift=1; in_data=-3 → -1; in_data=3 → 2. With RELU_EN, in_data=-40 → 0.
- Backpressure: out_ready=0 for 5 cycles → out_valid and out_data held stable, in_ready=0, offered in_valid beats not accepted. After the handshake, the next group's first beat is accepted one cycle later.
- Reset mid-group: cfg_len=4; after 2 beats assert rst_n low for 1 cycle → no output produced, in_ready=1. A new group of beats 1, 1, 1, 1 (bias 0, shift 0) → 4.
